// File: rtl/muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: MDControl opcodes,
// the sequencer states and a small opcode-classification helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // Signed ops work on magnitudes and restore the sign in FIX.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers.
// Multiply (shift-add) and divide (restoring) share one 2*WIDTH working register.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       MDControl,
  input  logic [WIDTH-1:0] scrA,
  input  logic [WIDTH-1:0] scrB,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   ITERS   = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  md_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic                 signed_op;
  logic                 a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]     a_abs, b_abs;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_shift, div_trial;
  logic [2*WIDTH-1:0]   div_step;

  // Operand conditioning at acceptance: magnitudes for signed ops.
  assign signed_op = is_signed_op(MDControl);
  assign a_neg     = signed_op & scrA[WIDTH-1];
  assign b_neg     = signed_op & scrB[WIDTH-1];
  assign a_abs     = a_neg ? -scrA : scrA;
  assign b_abs     = b_neg ? -scrB : scrB;
  assign b_zero    = (scrB == '0);

  // Multiply: work = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
  assign mul_step = {mul_sum, work_q[WIDTH-1:1]};

  // Divide: work = {partial remainder, dividend bits becoming quotient bits}.
  assign div_shift = work_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, opb_q};
  assign div_step  = div_trial[WIDTH]
                   ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

  always_comb begin
    // NOTE: every variable assigned here takes its current value first, so no
    // path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (MDControl)
            OP_MULT, OP_MULTU: begin
              state_d   = CALC;
              cnt_d     = ITERS;
              work_d    = {{WIDTH{1'b0}}, b_abs};
              opb_d     = a_abs;
              is_div_d  = 1'b0;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              if (b_zero) begin
                hi_d       = scrA;
                lo_d       = '1;
                done_d     = 1'b1;
                div_zero_d = 1'b1;
              end else begin
                state_d   = CALC;
                cnt_d     = ITERS;
                work_d    = {{WIDTH{1'b0}}, a_abs};
                opb_d     = b_abs;
                is_div_d  = 1'b1;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
              end
            end
            OP_MTHI: begin
              hi_d       = scrA;
              done_d     = 1'b1;
              div_zero_d = 1'b0;
            end
            OP_MTLO: begin
              lo_d       = scrA;
              done_d     = 1'b1;
              div_zero_d = 1'b0;
            end
            default: ;
          endcase
        end
      end

      CALC: begin
        cnt_d  = cnt_q - CNT_ONE;
        work_d = is_div_q ? div_step : mul_step;
        if (cnt_q == CNT_ONE) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        div_zero_d = 1'b0;
        if (is_div_q) begin
          lo_d = neg_res_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_res_q ? -work_q : work_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      opb_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      opb_q      <= opb_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign divZero = div_zero_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit for the MIPS datapath, run alongside the single-cycle ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO into internal HI/LO registers, using a start/busy/done handshake. The unit is parametrised in operand width. The control unit stalls on `busy` and reads HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits; legal range 4..64
- `clk` input 1 — single clock; all state updates on rising edge
- `reset_n` input 1 — asynchronous, active-low reset
- `start` input 1 — request; sampled only when `busy`=0
- `MDControl` input 3 — 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x invalid
- `scrA` input WIDTH — multiplicand / dividend / MTHI-MTLO source
- `scrB` input WIDTH — multiplier / divisor
- `busy` output 1 — operation in progress; new starts are ignored while high
- `done` output 1 — one-cycle pulse when HI/LO hold the new result
- `divZero` output 1 — qualified by `done`; high when the finished DIV/DIVU had `scrB`=0
- `HI` output WIDTH — high product half / remainder
- `LO` output WIDTH — low product half / quotient

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE → CALC on an accepted MULT/MULTU/DIV/DIVU with nonzero divisor for DIV/DIVU.
  - CALC → FIX after WIDTH iterations.
  - FIX → IDLE unconditionally.
- At acceptance, the unit latches:
  - |scrA| and |scrB| for signed ops, raw operands for unsigned ops
  - the result sign and the remainder sign, where remainder sign = dividend sign
  - the op
- Multiply: shift-add radix-2, one bit per CALC cycle, producing a 2·WIDTH unsigned product.
- Divide: restoring radix-2, one quotient bit per CALC cycle.
- FIX writes HI/LO:
  - Multiply: HI/LO = product, negated as 2·WIDTH if the result sign is set.
  - Divide: LO = quotient, negated if the result sign is set; HI = remainder, negated if the dividend was negative.
  - Quotient truncates toward zero.
- Signed overflow, −2^(WIDTH−1) / −1: LO = 0x80..0 (wraps), HI = 0. No flag.
- Divide by zero:
  - No CALC phase.
  - On the acceptance edge: HI = scrA, LO = all ones, `divZero`=1, `done` pulses next cycle.
- MTHI/MTLO:
  - On the acceptance edge, the selected register is loaded from scrA; the other register is unchanged.
  - `done` pulses next cycle; `busy` never rises.
- Invalid `MDControl` with `start`: ignored, no `done`, state unchanged.
- HI/LO hold their previous values throughout CALC; they change only on the FIX edge or the single-cycle write edge.

## Timing
- Reset (asynchronous, immediate, also mid-operation):
  - state IDLE, iteration counter 0
  - `busy`=0, `done`=0, `divZero`=0
  - HI=0, LO=0
  - any in-flight operation is discarded
- Multiply/divide with start accepted at edge E0:
  - `busy`=1 from E0 through the FIX edge E(WIDTH+1)
  - after E(WIDTH+1): `busy`=0, `done`=1 for one cycle, HI/LO valid
  - Latency is WIDTH+1 cycles from the accepting edge to `done` high (33 for WIDTH=32).
- `done` cycle is IDLE: a `start` presented in the same cycle as `done` is accepted (back-to-back ops).
- `start` while `busy`=1: ignored, not queued; operands may change freely.
- `divZero` updates only on the edges that also raise `done`; it clears on the next `done` of a non-zero-divide op.
- Iteration counter is $clog2(WIDTH+1) bits; it wraps only via reload at acceptance.

## Structure
- Shared package `muldiv_pkg` holds:
  - `md_op_t` enum for the 3-bit `MDControl` encodings
  - `md_state_t` enum {IDLE, CALC, FIX}
- Implement as one module: the multiply and divide datapaths share the 2·WIDTH working register and the counter. No sub-module.

## Test plan
Vectors are for WIDTH=32, each preceded by a reset.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` 33 cycles after the accept edge; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for exactly 33 cycles.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 26 / 15 → LO=1, HI=11. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 10 / 0 → `done` one cycle after accept, `divZero`=1, HI=10, LO=0xFFFFFFFF, `busy` never high.
- Start MULTU 3×2; during CALC assert `start` with DIVU → ignored, result HI=0, LO=6. Then reset_n low mid-CALC → `busy`=0 and HI=LO=0 immediately, with no `done`.
- MTHI 0x12345678 → `done` next cycle, HI=0x12345678, LO unchanged. Then `start` MTLO 0xA in the `done` cycle → accepted, LO=0xA. Then MDControl=110 with `start` → no `done`, no change.
